// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, round-constant table and key-schedule FSM states.
package aes_pkg;

    localparam int unsigned AES_NR = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ks_state_t;

    // Rcon[i] for rounds 1..10; round 0 has no constant.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] value;
        case (round)
            4'd1:    value = 8'h01;
            4'd2:    value = 8'h02;
            4'd3:    value = 8'h04;
            4'd4:    value = 8'h08;
            4'd5:    value = 8'h10;
            4'd6:    value = 8'h20;
            4'd7:    value = 8'h40;
            4'd8:    value = 8'h80;
            4'd9:    value = 8'h1b;
            4'd10:   value = 8'h36;
            default: value = 8'h00;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational lookup.
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] subst
);

    // Entry 0 sits in the top byte, so the lookup offset is (255 - value) * 8.
    localparam logic [2047:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] base;

    assign base  = {~value, 3'b000};
    assign subst = TABLE[base +: 8];

endmodule

// File: rtl/inv_key_sched.sv
// AES-128 inverse key schedule: walks round keys 10 down to 0 from the last round key.
module inv_key_sched
    import aes_pkg::*;
#(
    parameter int unsigned NR = aes_pkg::AES_NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] last_key,
    input  logic         ready,
    output logic         key_valid,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);

    ks_state_t    state;
    ks_state_t    state_next;
    logic [127:0] key_q;
    logic [3:0]   idx_q;
    logic         done_q;

    logic         load;
    logic         step;
    logic         finish;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rot;
    logic [31:0]  sub;
    logic [127:0] prev_key;

    assign {w0, w1, w2, w3} = key_q;
    assign p3  = w3 ^ w2;
    assign p2  = w2 ^ w1;
    assign p1  = w1 ^ w0;
    assign rot = {p3[23:0], p3[31:24]};

    aes_sbox u_sbox0 (.value(rot[7:0]),   .subst(sub[7:0]));
    aes_sbox u_sbox1 (.value(rot[15:8]),  .subst(sub[15:8]));
    aes_sbox u_sbox2 (.value(rot[23:16]), .subst(sub[23:16]));
    aes_sbox u_sbox3 (.value(rot[31:24]), .subst(sub[31:24]));

    assign p0       = w0 ^ sub ^ {rcon(idx_q), 24'h0};
    assign prev_key = {p0, p1, p2, p3};

    // done_q marks the first IDLE cycle after a run; start is ignored there.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !done_q) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (ready) begin
                    if (idx_q == 4'd0) begin
                        state_next = IDLE;
                        finish     = 1'b1;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            key_q  <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= finish;
            if (load) begin
                key_q <= last_key;
                idx_q <= 4'(NR);
            end else if (step) begin
                key_q <= prev_key;
                idx_q <= idx_q - 4'd1;
            end
        end
    end

    assign key_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = done_q;
    assign round_key = key_q;
    assign round_idx = idx_q;

endmodule
